// File: rtl/rv_muldiv.sv
// Iterative RV32M/RV64M multiply/divide unit: shift-add multiply, restoring divide, one bit per cycle.
// Optional MULDIV_FAST_MUL_EN: multiplies use a single-cycle combinational product instead.
module rv_muldiv #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam int CW = $clog2(XLEN);
   localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);
   localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t              state_q;
   logic [CW-1:0]       cnt_q;
   logic [2:0]          op_q;
   logic                negRes_q;
   logic [2*XLEN-1:0]   multiplicand_q;
   logic [XLEN-1:0]     multiplier_q;
   logic [2*XLEN-1:0]   product_q;
   logic [XLEN-1:0]     quotient_q;
   logic [XLEN-1:0]     remainder_q;
   logic [XLEN-1:0]     divisor_q;
   logic [XLEN-1:0]     result_q;
   logic                busy_q;
   logic                done_q;

   logic                isDiv, aSigned, bSigned, signA, signB;
   logic [XLEN-1:0]     magA, magB;
   logic                divZero, divOverflow, negStart;
   logic [XLEN-1:0]     scResult;

   logic [2*XLEN-1:0]   mulAcc;
   logic [XLEN:0]       divShift, divDiff;
   logic                divGe;
   logic [XLEN-1:0]     remNext, quoNext, divSel, divRes, calcResult;

   // Negate a 2*XLEN magnitude when the operand signs differ, then pick low or high half.
   function automatic logic [XLEN-1:0] mulSelect(input logic [2*XLEN-1:0] prod,
                                                 input logic neg, input logic [1:0] fn);
      logic [2*XLEN-1:0] signedProd;
      signedProd = neg ? -prod : prod;
      return (fn == 2'b00) ? signedProd[XLEN-1:0] : signedProd[2*XLEN-1:XLEN];
   endfunction

   // Operand decode for an incoming request: signedness, magnitudes and short-circuit cases.
   always_comb begin
      isDiv       = funct3[2];
      aSigned     = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                    (funct3 == 3'b100) || (funct3 == 3'b110);
      bSigned     = (funct3 == 3'b000) || (funct3 == 3'b001) ||
                    (funct3 == 3'b100) || (funct3 == 3'b110);
      signA       = aSigned && op_a[XLEN-1];
      signB       = bSigned && op_b[XLEN-1];
      magA        = signA ? -op_a : op_a;
      magB        = signB ? -op_b : op_b;
      divZero     = isDiv && (op_b == '0);
      divOverflow = isDiv && !funct3[0] && (op_a == MIN_NEG) && (op_b == '1);
      negStart    = (isDiv && funct3[1]) ? signA : (signA ^ signB);
      scResult    = '0;
      if (divZero)
         scResult = funct3[1] ? op_a : '1;
      else if (divOverflow)
         scResult = funct3[1] ? '0 : op_a;
   end

   // One iteration of both datapaths; only the one matching op_q matters for the result.
   always_comb begin
      mulAcc     = multiplier_q[0] ? (product_q + multiplicand_q) : product_q;
      divShift   = {remainder_q, quotient_q[XLEN-1]};
      divDiff    = divShift - {1'b0, divisor_q};
      divGe      = !divDiff[XLEN];
      remNext    = divGe ? divDiff[XLEN-1:0] : divShift[XLEN-1:0];
      quoNext    = {quotient_q[XLEN-2:0], divGe};
      divSel     = op_q[1] ? remNext : quoNext;
      divRes     = negRes_q ? -divSel : divSel;
      calcResult = op_q[2] ? divRes : mulSelect(mulAcc, negRes_q, op_q[1:0]);
   end

`ifdef MULDIV_FAST_MUL_EN
   logic [2*XLEN-1:0] fastProd;
   assign fastProd = {{XLEN{1'b0}}, magA} * {{XLEN{1'b0}}, magB};
`endif

   // Control FSM plus datapath registers; result only changes on entry to DONE.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= IDLE;
         cnt_q          <= '0;
         op_q           <= '0;
         negRes_q       <= 1'b0;
         multiplicand_q <= '0;
         multiplier_q   <= '0;
         product_q      <= '0;
         quotient_q     <= '0;
         remainder_q    <= '0;
         divisor_q      <= '0;
         result_q       <= '0;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               if (start) begin
                  op_q           <= funct3;
                  negRes_q       <= negStart;
                  cnt_q          <= '0;
                  product_q      <= '0;
                  multiplicand_q <= {{XLEN{1'b0}}, magA};
                  multiplier_q   <= magB;
                  quotient_q     <= magA;
                  remainder_q    <= '0;
                  divisor_q      <= magB;
                  if (divZero || divOverflow) begin
                     result_q <= scResult;
                     state_q  <= DONE;
                     busy_q   <= 1'b0;
                     done_q   <= 1'b1;
`ifdef MULDIV_FAST_MUL_EN
                  end else if (!isDiv) begin
                     result_q <= mulSelect(fastProd, negStart, funct3[1:0]);
                     state_q  <= DONE;
                     busy_q   <= 1'b0;
                     done_q   <= 1'b1;
`endif
                  end else begin
                     state_q <= CALC;
                     busy_q  <= 1'b1;
                     done_q  <= 1'b0;
                  end
               end else begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b0;
               end
            end
            CALC: begin
               cnt_q          <= cnt_q + 1'b1;
               product_q      <= mulAcc;
               multiplicand_q <= multiplicand_q << 1;
               multiplier_q   <= multiplier_q >> 1;
               remainder_q    <= remNext;
               quotient_q     <= quoNext;
               if (cnt_q == CNT_LAST) begin
                  result_q <= calcResult;
                  state_q  <= DONE;
                  busy_q   <= 1'b0;
                  done_q   <= 1'b1;
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign result = result_q;

endmodule

// File: tb/tb_rv_muldiv.sv
// Directed self-checking bench for rv_muldiv (XLEN=32), covering both multiply build options.
module tb_rv_muldiv;

   localparam int XLEN = 32;
`ifdef MULDIV_FAST_MUL_EN
   localparam int MUL_EDGES = 1;
   localparam int MUL_BUSY  = 0;
`else
   localparam int MUL_EDGES = 33;
   localparam int MUL_BUSY  = 32;
`endif
   localparam int DIV_EDGES = 33;

   localparam logic [2:0] F_MUL = 3'b000, F_MULH = 3'b001, F_MULHSU = 3'b010, F_MULHU = 3'b011;
   localparam logic [2:0] F_DIV = 3'b100, F_DIVU = 3'b101, F_REM = 3'b110, F_REMU = 3'b111;

   logic            clk = 1'b0;
   logic            rst;
   logic            start;
   logic [2:0]      funct3;
   logic [XLEN-1:0] op_a, op_b;
   logic            busy, done;
   logic [XLEN-1:0] result;

   int checks = 0;
   int errors = 0;
   int edges, busyCycles, extra;

   always #5 clk = ~clk;

   rv_muldiv #(.XLEN(XLEN)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .funct3 (funct3),
      .op_a   (op_a),
      .op_b   (op_b),
      .busy   (busy),
      .done   (done),
      .result (result)
   );

   task automatic checkOutput(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Drives a request; caller is positioned just after a rising edge.
   task automatic applyStimulus(input logic [2:0] f, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
      funct3 = f;
      op_a   = a;
      op_b   = b;
      start  = 1'b1;
   endtask

   // Counts edges until done is seen, bounded so a stuck DUT still reaches the summary.
   task automatic waitDone(output int nEdges, output int nBusy);
      nEdges = 0;
      nBusy  = 0;
      for (int i = 0; i < 200; i++) begin
         @(posedge clk);
         #1;
         start = 1'b0;
         nEdges++;
         if (busy) nBusy++;
         if (done) break;
      end
   endtask

   task automatic runOp(input string tag, input logic [2:0] f, input logic [XLEN-1:0] a,
                        input logic [XLEN-1:0] b, input logic [XLEN-1:0] expRes, input int expEdges);
      int e, bc;
      applyStimulus(f, a, b);
      waitDone(e, bc);
      checkOutput({tag, "_result"}, result, expRes);
      checkOutput({tag, "_edges"}, XLEN'(e), XLEN'(expEdges));
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; funct3 = '0; op_a = '0; op_b = '0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_busy", {31'b0, busy}, 32'd0);
      checkOutput("reset_done", {31'b0, done}, 32'd0);
      checkOutput("reset_result", result, 32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      applyStimulus(F_MUL, 32'd7, 32'hFFFF_FFFD);
      waitDone(edges, busyCycles);
      checkOutput("mul_result", result, 32'hFFFF_FFEB);
      checkOutput("mul_edges", XLEN'(edges), XLEN'(MUL_EDGES));
      checkOutput("mul_busy_cycles", XLEN'(busyCycles), XLEN'(MUL_BUSY));
      @(posedge clk);
      #1;
      checkOutput("hold_result", result, 32'hFFFF_FFEB);
      checkOutput("hold_done", {31'b0, done}, 32'd0);

      runOp("mulh",   F_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_EDGES);
      runOp("mulhu",  F_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_EDGES);
      runOp("mulhsu", F_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_EDGES);
      runOp("div",    F_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, DIV_EDGES);
      runOp("rem",    F_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, DIV_EDGES);
      runOp("divu",   F_DIVU,   32'd100,       32'd7,         32'd14,        DIV_EDGES);
      runOp("remu",   F_REMU,   32'd100,       32'd7,         32'd2,         DIV_EDGES);
      runOp("divu0",  F_DIVU,   32'd5,         32'd0,         32'hFFFF_FFFF, 1);
      runOp("remu0",  F_REMU,   32'd5,         32'd0,         32'd5,         1);
      runOp("divovf", F_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
      runOp("removf", F_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);

      // A start pulse during CALC cycle 10 must not disturb the running divide.
      applyStimulus(F_DIVU, 32'd1000, 32'd10);
      for (int i = 0; i < 11; i++) begin
         @(posedge clk);
         #1;
         start = 1'b0;
      end
      checkOutput("inflight_busy", {31'b0, busy}, 32'd1);
      applyStimulus(F_REMU, 32'd7, 32'd3);
      waitDone(extra, busyCycles);
      checkOutput("inflight_result", result, 32'd100);
      checkOutput("inflight_edges", XLEN'(11 + extra), XLEN'(DIV_EDGES));

      // Reset five cycles into CALC discards the op and clears the outputs.
      applyStimulus(F_DIVU, 32'd1000, 32'd7);
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         #1;
         start = 1'b0;
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("midrst_busy", {31'b0, busy}, 32'd0);
      checkOutput("midrst_done", {31'b0, done}, 32'd0);
      checkOutput("midrst_result", result, 32'd0);
      rst = 1'b0;
      runOp("postrst_divu", F_DIVU, 32'd9, 32'd3, 32'd3, DIV_EDGES);

      // Back-to-back: the second start is taken in the DONE cycle of the first.
      @(posedge clk);
      #1;
      applyStimulus(F_MUL, 32'd3, 32'd4);
      waitDone(edges, busyCycles);
      checkOutput("b2b_first_result", result, 32'd12);
      checkOutput("b2b_first_edges", XLEN'(edges), XLEN'(MUL_EDGES));
      applyStimulus(F_DIVU, 32'd20, 32'd5);
      @(posedge clk);
      #1;
      start = 1'b0;
      checkOutput("b2b_no_idle_gap", {31'b0, busy}, 32'd1);
      waitDone(extra, busyCycles);
      checkOutput("b2b_second_result", result, 32'd4);
      checkOutput("b2b_second_edges", XLEN'(1 + extra), XLEN'(DIV_EDGES));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
